instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit on the requesting side of the instruction ROM.
- Holds the byte-addressed PC and drives the ROM word address.
- Absorbs the ROM's one-cycle registered read latency.
- Presents instructions to decode through a VALID/READY handshake with a one-entry skid buffer, so no word is dropped or duplicated under stall.
- Sits between the instruction ROM and the decode stage; branch/jump logic redirects it.

## Interface
Parameters:
- ROM_SIZE, 64, ROM depth in 32-bit words; must match the instruction ROM instance.
- RESET_PC, 32'h0000_0000, byte address fetched first after reset; must be word-aligned.

Ports:
- CLK  input  1  single clock; all state updates on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- ROM_ADDR  output  32  word index to the ROM; ROM returns ROM_DATA one cycle later.
- ROM_DATA  input  32  ROM read data for the address presented in the previous cycle.
- REDIRECT  input  1  single-cycle request to flush and restart fetch at REDIRECT_PC.
- REDIRECT_PC  input  32  new byte PC; bits [1:0] are ignored.
- INSTR_READY  input  1  decode accepts INSTR this cycle.
- INSTR_VALID  output  1  INSTR/INSTR_PC hold a valid instruction.
- INSTR  output  32  instruction word.
- INSTR_PC  output  32  byte PC of INSTR.
- FETCH_FAULT  output  1  out-of-range fetch flag; tied 0 unless FETCH_BOUND_CHECK_EN is defined.

## Operation
- ROM_ADDR = {2'b00, issue_pc[31:2]} combinationally. When REDIRECT=1, issue_pc is replaced by REDIRECT_PC in the same cycle.
- Issue: when issue_en=1, at the edge issue_pc <= issue_pc+4 and the in-flight tag is set: req_valid <= 1, req_pc <= issued PC.
- issue_en = !skid_valid && !(INSTR_VALID && !INSTR_READY && req_valid). This guarantees a landing slot for every in-flight word.
- Landing: when req_valid=1, ROM_DATA/req_pc go to the output register if it is empty or being drained this cycle; otherwise they go to the skid buffer.
- Drain: when INSTR_VALID && INSTR_READY, the output register loads from the skid buffer if it is full, else from the landing word, else it clears.
- Occupancy FSM (output/skid):
  - EMPTY -> FULL on a landing.
  - FULL -> SKID on landing && !INSTR_READY.
  - FULL -> EMPTY on drain with no landing.
  - SKID -> FULL on drain.
- REDIRECT has priority over everything:
  - clears req_valid, skid_valid and INSTR_VALID at the edge, even if decode accepts in that cycle; that transfer is discarded;
  - issues REDIRECT_PC;
  - sets issue_pc <= REDIRECT_PC+4.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0.

## Timing
- Reset values:
  - INSTR_VALID=0, INSTR=0, INSTR_PC=0, FETCH_FAULT=0;
  - req_valid=0, skid_valid=0;
  - issue_pc=RESET_PC, so ROM_ADDR=RESET_PC>>2 during reset.
- After RST_N rises: first issue at edge 1; INSTR_VALID=1 after edge 2.
- Redirect latency: REDIRECT in cycle T -> target instruction valid in cycle T+2.
- Sustained throughput is 1 instruction/cycle while INSTR_READY=1.
- Once INSTR_VALID=1, INSTR/INSTR_PC are held stable until accepted or flushed.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous); in-flight words are lost.

## Configuration
- FETCH_BOUND_CHECK_EN defined:
  - an issue whose word index is >= ROM_SIZE is suppressed (no req_valid, issue_pc not advanced);
  - FETCH_FAULT is set and stays sticky until REDIRECT or reset;
  - already-landed words still drain normally.
- FETCH_BOUND_CHECK_EN undefined:
  - no range check, and ROM_ADDR is passed through unchanged;
  - FETCH_FAULT is constant 0.

## Structure
- Shared package mips_fetch_pkg:
  - occupancy state enum (EMPTY, FULL, SKID);
  - WORD_BYTES=4;
  - PC_WIDTH=32.
- Sub-module fetch_skid_buf: one-entry {data, pc} buffer with load/unload/flush, instantiated once. Issue/PC logic and the output register stay in instr_fetch.

## Test plan
- Reset release, INSTR_READY=1, ROM word i = 32'h1000_0000+i -> INSTR_VALID rises after edge 2; INSTR_PC sequence 0,4,8,...; INSTR 32'h1000_0000, 32'h1000_0001,... with no gaps.
- INSTR_READY=0 for 3 cycles in a steady stream -> skid fills once; ROM_ADDR is held; on release, the next PCs follow with none missing or repeated.
- REDIRECT with REDIRECT_PC=32'h0000_0020 while the skid buffer is full -> everything flushed; first valid INSTR_PC=32'h20 two cycles later.
- REDIRECT in the same cycle as INSTR_VALID&&INSTR_READY -> the accepted word is discarded; the next valid is the redirect target.
- RST_N pulsed low mid-stream with the skid buffer full -> outputs go to 0 immediately; fetch restarts at RESET_PC.
- With FETCH_BOUND_CHECK_EN defined, REDIRECT_PC=32'h0000_00FC (word 63), ROM_SIZE=64 -> word 63 is delivered, then FETCH_FAULT=1 with no further INSTR_VALID; a later REDIRECT to 0 clears FETCH_FAULT.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared fetch definitions: occupancy states, PC geometry and address helpers.
package mips_fetch_pkg;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned PC_WIDTH   = 32;

  // Occupancy of the output register plus skid buffer.
  typedef enum logic [1:0] {
    StEmpty,
    StFull,
    StSkid
  } occ_state_e;

  // Byte PC -> ROM word index.
  function automatic logic [PC_WIDTH-1:0] word_index(logic [PC_WIDTH-1:0] pc);
    return pc >> 2;
  endfunction

  // Force a byte PC onto a word boundary.
  function automatic logic [PC_WIDTH-1:0] align_pc(logic [PC_WIDTH-1:0] pc);
    return pc & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch -> decode instruction handshake (valid/ready with word and its byte PC).
interface instr_fetch_if;
  import mips_fetch_pkg::*;

  logic                valid;
  logic                ready;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] pc;

  modport master (output valid, output instr, output pc, input ready);
  modport slave  (input valid, input instr, input pc, output ready);
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {data, pc} holding buffer; flush beats load beats unload.
module fetch_skid_buf
  import mips_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                load_i,
  input  logic                unload_i,
  input  logic [31:0]         data_i,
  input  logic [PC_WIDTH-1:0] pc_i,
  output logic                valid_o,
  output logic [31:0]         data_o,
  output logic [PC_WIDTH-1:0] pc_o
);

  logic                valid_q, valid_d;
  logic [31:0]         data_q, data_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;

  // Next-state for the single entry.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
      pc_d    = pc_i;
    end else if (unload_i) begin
      valid_d = 1'b0;
    end
  end

  // Entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC/issue logic, ROM latency absorption, output register + skid buffer.
// Optional macro FETCH_BOUND_CHECK_EN: suppress fetches at word index >= ROM_SIZE and raise
// a sticky fetch_fault until redirect or reset.
module instr_fetch
  import mips_fetch_pkg::*;
#(
  parameter int unsigned         ROM_SIZE = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [31:0]         rom_addr,
  input  logic [31:0]         rom_data,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  instr_fetch_if.master       dec,
  output logic                fetch_fault
);

  occ_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic                req_valid_q, req_valid_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [31:0]         out_instr_q, out_instr_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;

  logic [PC_WIDTH-1:0] issue_pc_cur;
  logic                drain, landing, issue_en, in_range;
  logic                skid_load, skid_unload, skid_valid;
  logic [31:0]         skid_data;
  logic [PC_WIDTH-1:0] skid_pc;

  // Redirect takes over the address in the same cycle it is requested.
  assign issue_pc_cur = redirect ? align_pc(redirect_pc) : issue_pc_q;
  assign rom_addr     = word_index(issue_pc_cur);
  assign drain        = (state_q != StEmpty) && dec.ready;
  assign landing      = req_valid_q;
  // Only issue when the word returning next cycle is sure to find a slot.
  assign issue_en     = !skid_valid && !((state_q != StEmpty) && !dec.ready && req_valid_q);

`ifdef FETCH_BOUND_CHECK_EN
  logic fault_q, fault_d;

  assign in_range = word_index(issue_pc_cur) < ROM_SIZE;

  // Sticky fault: set by a suppressed issue, re-evaluated on redirect.
  always_comb begin
    fault_d = fault_q;
    if (redirect) begin
      fault_d = !in_range;
    end else if (issue_en && !in_range) begin
      fault_d = 1'b1;
    end
  end

  // Fault flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fetch_fault = fault_q;
`else
  logic unused_rom_size;

  assign in_range        = 1'b1;
  assign fetch_fault     = 1'b0;
  assign unused_rom_size = (ROM_SIZE != 0);
`endif

  // Issue, landing/drain routing and occupancy next-state.
  always_comb begin
    state_d     = state_q;
    issue_pc_d  = issue_pc_q;
    req_valid_d = 1'b0;
    req_pc_d    = req_pc_q;
    out_instr_d = out_instr_q;
    out_pc_d    = out_pc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    if (redirect) begin
      // Flush everything, including a word being accepted this cycle.
      state_d = StEmpty;
      if (in_range) begin
        req_valid_d = 1'b1;
        req_pc_d    = issue_pc_cur;
        issue_pc_d  = issue_pc_cur + WORD_BYTES;
      end else begin
        issue_pc_d = issue_pc_cur;
      end
    end else begin
      if (issue_en && in_range) begin
        req_valid_d = 1'b1;
        req_pc_d    = issue_pc_cur;
        issue_pc_d  = issue_pc_cur + WORD_BYTES;
      end
      unique case (state_q)
        StEmpty: begin
          if (landing) begin
            out_instr_d = rom_data;
            out_pc_d    = req_pc_q;
            state_d     = StFull;
          end
        end
        StFull: begin
          if (drain) begin
            if (landing) begin
              out_instr_d = rom_data;
              out_pc_d    = req_pc_q;
            end else begin
              state_d = StEmpty;
            end
          end else if (landing) begin
            skid_load = 1'b1;
            state_d   = StSkid;
          end
        end
        StSkid: begin
          // No word can be in flight while the skid is full.
          if (drain) begin
            out_instr_d = skid_data;
            out_pc_d    = skid_pc;
            skid_unload = 1'b1;
            state_d     = StFull;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      issue_pc_q  <= RESET_PC;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      out_instr_q <= '0;
      out_pc_q    <= '0;
    end else begin
      state_q     <= state_d;
      issue_pc_q  <= issue_pc_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      out_instr_q <= out_instr_d;
      out_pc_q    <= out_pc_d;
    end
  end

  fetch_skid_buf u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush_i  (redirect),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .data_i   (rom_data),
    .pc_i     (req_pc_q),
    .valid_o  (skid_valid),
    .data_o   (skid_data),
    .pc_o     (skid_pc)
  );

  assign dec.valid = (state_q != StEmpty);
  assign dec.instr = out_instr_q;
  assign dec.pc    = out_pc_q;

endmodule
